// File: rtl/cx_alu_pkg.sv
// Shared op codes, latency defaults and helpers for the complex ALU issue scheduler.
package cx_alu_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned OP_W        = 3;
   localparam int unsigned DEF_MUL_LAT = 3;
   localparam int unsigned DEF_DIV_LAT = 6;
   localparam int unsigned DEF_SHF_LAT = 1;
   localparam int unsigned DEF_MAX_LAT = 8;
   localparam int unsigned DEF_TAG_W   = 5;

   localparam logic [OP_W-1:0] OP_NONE = 3'd0;
   localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
   localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
   localparam logic [OP_W-1:0] OP_MOD  = 3'd3;
   localparam logic [OP_W-1:0] OP_SHL  = 3'd4;
   localparam logic [OP_W-1:0] OP_SHR  = 3'd5;

   // Per-slot bookkeeping; illegal ops are stored with op = OP_NONE and err = 1.
   typedef struct packed {
      logic            valid;
      logic            err;
      logic [OP_W-1:0] op;
   } slot_meta_t;

   function automatic int unsigned lat_of(input logic [OP_W-1:0] op,
                                          input int unsigned     mul_lat,
                                          input int unsigned     div_lat,
                                          input int unsigned     shf_lat);
      int unsigned lat;
      case (op)
         OP_MUL:         lat = mul_lat;
         OP_DIV, OP_MOD: lat = div_lat;
         OP_SHL, OP_SHR: lat = shf_lat;
         default:        lat = 32'd1;
      endcase
      return lat;
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
      return (op >= OP_MUL) && (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/cx_slot_pipe.sv
// Writeback-slot reservation pipeline: entry i completes i cycles from now.
module cx_slot_pipe
   import cx_alu_pkg::*;
#(
   parameter int unsigned MAX_LAT = DEF_MAX_LAT,
   parameter int unsigned TAG_W   = DEF_TAG_W,
   parameter int unsigned IDX_W   = $clog2(DEF_MAX_LAT + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             flush_i,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  slot_meta_t       wr_meta_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   output logic [MAX_LAT:1] resv_sh_o,
   output logic [MAX_LAT:1] resv_nxt_o,
   output logic             head_valid_o,
   output logic             head_err_o,
   output logic [TAG_W-1:0] head_tag_o,
   output logic [OP_W-1:0]  nxt_op_o
);

   slot_meta_t       meta_q  [MAX_LAT:1];
   slot_meta_t       meta_sh [MAX_LAT:1];
   slot_meta_t       meta_d  [MAX_LAT:1];
   logic [TAG_W-1:0] tag_q   [MAX_LAT:1];
   logic [TAG_W-1:0] tag_d   [MAX_LAT:1];

   // Shift toward slot 1, then either wipe everything or insert the new issue.
   always_comb begin
      for (int i = 1; i < MAX_LAT; i++) begin
         meta_sh[i] = meta_q[i+1];
         tag_d[i]   = tag_q[i+1];
      end
      meta_sh[MAX_LAT] = '0;
      tag_d[MAX_LAT]   = '0;
      meta_d = meta_sh;
      if (flush_i) begin
         for (int i = 1; i <= MAX_LAT; i++) begin
            meta_d[i] = '0;
            tag_d[i]  = '0;
         end
      end else if (wr_en_i) begin
         meta_d[wr_idx_i] = wr_meta_i;
         tag_d[wr_idx_i]  = wr_tag_i;
      end
      for (int i = 1; i <= MAX_LAT; i++) begin
         resv_sh_o[i]  = meta_sh[i].valid;
         resv_nxt_o[i] = meta_d[i].valid;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 1; i <= MAX_LAT; i++) begin
            meta_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         meta_q <= meta_d;
         tag_q  <= tag_d;
      end
   end

   assign head_valid_o = meta_q[1].valid;
   assign head_err_o   = meta_q[1].err;
   assign head_tag_o   = tag_q[1];
   assign nxt_op_o     = meta_d[1].op;

endmodule

// File: rtl/complex_alu_sched.sv
// Issue scheduler for the multi-cycle ALU: drives operands, times the result
// select and refuses issues whose completion cycle is already reserved.
module complex_alu_sched
   import cx_alu_pkg::*;
#(
   parameter int unsigned MUL_LAT = DEF_MUL_LAT,
   parameter int unsigned DIV_LAT = DEF_DIV_LAT,
   parameter int unsigned SHF_LAT = DEF_SHF_LAT,
   parameter int unsigned MAX_LAT = DEF_MAX_LAT,
   parameter int unsigned TAG_W   = DEF_TAG_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [OP_W-1:0]   issue_op,
   input  logic [DATA_W-1:0] issue_srcA,
   input  logic [DATA_W-1:0] issue_srcB,
   input  logic [TAG_W-1:0]  issue_tag,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_srcA,
   output logic [DATA_W-1:0] alu_srcB,
   output logic [OP_W-1:0]   alu_select,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wb_valid,
   output logic [TAG_W-1:0]  wb_tag,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_err,
   output logic              busy
);

   localparam int unsigned IDX_W = $clog2(MAX_LAT + 1);

   if (MUL_LAT < 1 || MUL_LAT > MAX_LAT || DIV_LAT < 1 || DIV_LAT > MAX_LAT ||
       SHF_LAT < 1 || SHF_LAT > MAX_LAT) begin : g_bad_lat
      $error("complex_alu_sched: every unit latency must lie in 1..MAX_LAT");
   end

   logic [MAX_LAT:1] resv_sh;
   logic [MAX_LAT:1] resv_nxt;
   logic             head_valid;
   logic             head_err;
   logic [TAG_W-1:0] head_tag;
   logic [OP_W-1:0]  nxt_op;
   logic [IDX_W-1:0] lat_idx;
   logic             legal;
   logic             fire;
   slot_meta_t       wr_meta;

   logic              ready_en_q;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_srca_q, alu_srca_d;
   logic [DATA_W-1:0] alu_srcb_q, alu_srcb_d;
   logic [OP_W-1:0]   alu_select_q, alu_select_d;
   logic              wb_valid_q, wb_valid_d;
   logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              wb_err_q, wb_err_d;
   logic              busy_q, busy_d;

   // Acceptance looks at the post-shift reservation bit for this op's latency.
   always_comb begin
      lat_idx       = IDX_W'(lat_of(issue_op, MUL_LAT, DIV_LAT, SHF_LAT));
      legal         = is_legal(issue_op);
      issue_ready   = ready_en_q & ~flush & ~resv_sh[lat_idx];
      fire          = issue_valid & issue_ready;
      wr_meta       = '0;
      wr_meta.valid = 1'b1;
      wr_meta.err   = ~legal;
      wr_meta.op    = legal ? issue_op : OP_NONE;
   end

   cx_slot_pipe #(
      .MAX_LAT (MAX_LAT),
      .TAG_W   (TAG_W),
      .IDX_W   (IDX_W)
   ) u_slot_pipe (
      .clock        (clock),
      .resetn       (resetn),
      .flush_i      (flush),
      .wr_en_i      (fire),
      .wr_idx_i     (lat_idx),
      .wr_meta_i    (wr_meta),
      .wr_tag_i     (issue_tag),
      .resv_sh_o    (resv_sh),
      .resv_nxt_o   (resv_nxt),
      .head_valid_o (head_valid),
      .head_err_o   (head_err),
      .head_tag_o   (head_tag),
      .nxt_op_o     (nxt_op)
   );

   always_comb begin
      alu_op_d   = OP_NONE;
      alu_srca_d = '0;
      alu_srcb_d = '0;
      if (fire && legal) begin
         alu_op_d   = issue_op;
         alu_srca_d = issue_srcA;
         alu_srcb_d = issue_srcB;
      end
      // Select is loaded one cycle early so it lines up with slot 1.
      alu_select_d = nxt_op;
      wb_valid_d   = head_valid & ~flush;
      wb_err_d     = wb_valid_d & head_err;
      wb_tag_d     = wb_valid_d ? head_tag : '0;
      wb_data_d    = (wb_valid_d && !head_err) ? alu_result : '0;
      busy_d       = (|resv_nxt) | wb_valid_d;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ready_en_q   <= 1'b0;
         alu_op_q     <= OP_NONE;
         alu_srca_q   <= '0;
         alu_srcb_q   <= '0;
         alu_select_q <= OP_NONE;
         wb_valid_q   <= 1'b0;
         wb_tag_q     <= '0;
         wb_data_q    <= '0;
         wb_err_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         ready_en_q   <= 1'b1;
         alu_op_q     <= alu_op_d;
         alu_srca_q   <= alu_srca_d;
         alu_srcb_q   <= alu_srcb_d;
         alu_select_q <= alu_select_d;
         wb_valid_q   <= wb_valid_d;
         wb_tag_q     <= wb_tag_d;
         wb_data_q    <= wb_data_d;
         wb_err_q     <= wb_err_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_srcA   = alu_srca_q;
   assign alu_srcB   = alu_srcb_q;
   assign alu_select = alu_select_q;
   assign wb_valid   = wb_valid_q;
   assign wb_tag     = wb_tag_q;
   assign wb_data    = wb_data_q;
   assign wb_err     = wb_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_complex_alu_sched.sv
// Directed bench for complex_alu_sched with a behavioural multi-cycle ALU model.
module tb_complex_alu_sched;
   import cx_alu_pkg::*;

   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned DIV_LAT = 6;
   localparam int unsigned SHF_LAT = 1;
   localparam int unsigned MAX_LAT = 8;
   localparam int unsigned TAG_W   = 5;

   logic              clock;
   logic              resetn;
   logic              flush;
   logic              issue_valid;
   logic              issue_ready;
   logic [2:0]        issue_op;
   logic [31:0]       issue_srcA;
   logic [31:0]       issue_srcB;
   logic [TAG_W-1:0]  issue_tag;
   logic [2:0]        alu_op;
   logic [31:0]       alu_srcA;
   logic [31:0]       alu_srcB;
   logic [2:0]        alu_select;
   logic [31:0]       alu_result;
   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic [31:0]       wb_data;
   logic              wb_err;
   logic              busy;

   int checks;
   int errors;

   complex_alu_sched #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT),
      .SHF_LAT (SHF_LAT),
      .MAX_LAT (MAX_LAT),
      .TAG_W   (TAG_W)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_srcA  (issue_srcA),
      .issue_srcB  (issue_srcB),
      .issue_tag   (issue_tag),
      .alu_op      (alu_op),
      .alu_srcA    (alu_srcA),
      .alu_srcB    (alu_srcB),
      .alu_select  (alu_select),
      .alu_result  (alu_result),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .wb_data     (wb_data),
      .wb_err      (wb_err),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ALU model: mul/div/mod pipelines deliver L-1 cycles after operands; shifts are same-cycle.
   logic [31:0] upipe [1:3][0:7];
   always @(posedge clock) begin
      for (int u = 1; u <= 3; u++)
         for (int k = 0; k < 7; k++) upipe[u][k] <= upipe[u][k+1];
      case (alu_op)
         OP_MUL:  upipe[1][MUL_LAT-2] <= alu_srcA * alu_srcB;
         OP_DIV:  upipe[2][DIV_LAT-2] <= alu_srcA / alu_srcB;
         OP_MOD:  upipe[3][DIV_LAT-2] <= alu_srcA % alu_srcB;
         default: ;
      endcase
   end

   always_comb begin
      case (alu_select)
         OP_MUL:  alu_result = upipe[1][0];
         OP_DIV:  alu_result = upipe[2][0];
         OP_MOD:  alu_result = upipe[3][0];
         OP_SHL:  alu_result = alu_srcA << alu_srcB[4:0];
         OP_SHR:  alu_result = alu_srcA >> alu_srcB[4:0];
         default: alu_result = '0;
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t);
      issue_valid = v;
      issue_op    = op;
      issue_srcA  = a;
      issue_srcB  = b;
      issue_tag   = t;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      flush  = 1'b0;
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      repeat (3) @(posedge clock);
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0d want 0", issue_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
      checks++; if (wb_valid !== 1'b0 || alu_op !== 3'd0 || alu_select !== 3'd0) begin errors++;
         $display("FAIL reset_outputs: wb_valid=%0d alu_op=%0d alu_select=%0d want 0", wb_valid, alu_op, alu_select); end
      resetn = 1'b1;
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %0d want 0", issue_ready); end
      tick();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %0d want 1", issue_ready); end
   endtask

   task automatic test_mul();
      drive(1'b1, OP_MUL, 32'd7, 32'd6, 5'd3);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mul_ready: got %0d want 1", issue_ready); end
      tick(); // N+1
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      checks++; if (alu_op !== OP_MUL || alu_srcA !== 32'd7 || alu_srcB !== 32'd6) begin errors++;
         $display("FAIL mul_alu_drive: op=%0d a=%0d b=%0d want 1 7 6", alu_op, alu_srcA, alu_srcB); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %0d want 1", busy); end
      tick(); // N+2
      checks++; if (alu_op !== 3'd0 || alu_select !== 3'd0) begin errors++;
         $display("FAIL mul_n2: alu_op=%0d alu_select=%0d want 0 0", alu_op, alu_select); end
      tick(); // N+3
      checks++; if (alu_select !== OP_MUL || wb_valid !== 1'b0) begin errors++;
         $display("FAIL mul_select: alu_select=%0d wb_valid=%0d want 1 0", alu_select, wb_valid); end
      tick(); // N+4
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_tag !== 5'd3 || wb_err !== 1'b0) begin errors++;
         $display("FAIL mul_wb: valid=%0d data=%0d tag=%0d err=%0d want 1 42 3 0", wb_valid, wb_data, wb_tag, wb_err); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_wb: got %0d want 1", busy); end
      tick(); // N+5
      checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL mul_done: wb_valid=%0d busy=%0d want 0 0", wb_valid, busy); end
   endtask

   task automatic test_div_mod();
      logic             exp_v;
      logic [31:0]      exp_d;
      logic [TAG_W-1:0] exp_t;
      drive(1'b1, OP_DIV, 32'd100, 32'd7, 5'd1);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL div_ready: got %0d want 1", issue_ready); end
      tick(); // N+1
      drive(1'b1, OP_MOD, 32'd100, 32'd7, 5'd2);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mod_ready: got %0d want 1", issue_ready); end
      tick(); // N+2
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      for (int c = 2; c <= 9; c++) begin
         exp_v = (c == 7) || (c == 8);
         exp_d = (c == 7) ? 32'd14 : ((c == 8) ? 32'd2 : 32'd0);
         exp_t = (c == 7) ? 5'd1 : ((c == 8) ? 5'd2 : 5'd0);
         checks++;
         if (wb_valid !== exp_v || (exp_v && (wb_data !== exp_d || wb_tag !== exp_t))) begin errors++;
            $display("FAIL divmod_wb c=%0d: valid=%0d data=%0d tag=%0d want %0d %0d %0d",
                     c, wb_valid, wb_data, wb_tag, exp_v, exp_d, exp_t); end
         tick();
      end
   endtask

   task automatic test_conflict();
      logic             exp_v;
      logic [31:0]      exp_d;
      logic [TAG_W-1:0] exp_t;
      drive(1'b1, OP_DIV, 32'd50, 32'd5, 5'd4);
      tick(); // N+1
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      tick(); // N+2
      tick(); // N+3
      drive(1'b1, OP_MUL, 32'd3, 32'd3, 5'd5);
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL conflict_mul_ready: got %0d want 0", issue_ready); end
      drive(1'b1, OP_SHL, 32'd1, 32'd3, 5'd6);
      #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL conflict_shl_ready: got %0d want 1", issue_ready); end
      tick(); // N+4
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      checks++; if (alu_op !== OP_SHL || alu_select !== OP_SHL) begin errors++;
         $display("FAIL conflict_shl_drive: alu_op=%0d alu_select=%0d want 4 4", alu_op, alu_select); end
      for (int c = 4; c <= 8; c++) begin
         exp_v = (c == 5) || (c == 7);
         exp_d = (c == 5) ? 32'd8 : ((c == 7) ? 32'd10 : 32'd0);
         exp_t = (c == 5) ? 5'd6 : ((c == 7) ? 5'd4 : 5'd0);
         checks++;
         if (wb_valid !== exp_v || (exp_v && (wb_data !== exp_d || wb_tag !== exp_t))) begin errors++;
            $display("FAIL conflict_wb c=%0d: valid=%0d data=%0d tag=%0d want %0d %0d %0d",
                     c, wb_valid, wb_data, wb_tag, exp_v, exp_d, exp_t); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic             exp_v;
      logic [31:0]      exp_d;
      logic [TAG_W-1:0] exp_t;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         if (cyc < 8) begin
            drive(1'b1, OP_SHL, 32'd1, 32'(cyc), TAG_W'(cyc));
            #1;
            checks++; if (issue_ready !== 1'b1) begin errors++;
               $display("FAIL b2b_ready cyc=%0d: got %0d want 1", cyc, issue_ready); end
         end else begin
            drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
         end
         exp_v = (cyc >= 2) && (cyc < 10);
         exp_d = exp_v ? (32'd1 << (cyc - 2)) : 32'd0;
         exp_t = exp_v ? TAG_W'(cyc - 2) : '0;
         checks++;
         if (wb_valid !== exp_v || (exp_v && (wb_data !== exp_d || wb_tag !== exp_t))) begin errors++;
            $display("FAIL b2b_wb cyc=%0d: valid=%0d data=%0d tag=%0d want %0d %0d %0d",
                     cyc, wb_valid, wb_data, wb_tag, exp_v, exp_d, exp_t); end
         tick();
      end
   endtask

   task automatic test_flush();
      drive(1'b1, OP_MUL, 32'd5, 32'd5, 5'd7);
      tick(); // N+1
      flush = 1'b1;
      drive(1'b1, OP_SHL, 32'd1, 32'd1, 5'd8);
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0d want 0", issue_ready); end
      tick(); // N+2
      flush = 1'b0;
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      checks++; if (busy !== 1'b0 || alu_op !== 3'd0) begin errors++;
         $display("FAIL flush_clear: busy=%0d alu_op=%0d want 0 0", busy, alu_op); end
      for (int c = 2; c <= 7; c++) begin
         checks++; if (wb_valid !== 1'b0) begin errors++;
            $display("FAIL flush_no_wb c=%0d: wb_valid=%0d want 0", c, wb_valid); end
         tick();
      end
   endtask

   task automatic test_illegal();
      drive(1'b1, 3'd6, 32'd1, 32'd2, 5'd9);
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %0d want 1", issue_ready); end
      tick(); // N+1
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      checks++; if (alu_op !== 3'd0 || alu_srcA !== 32'd0 || alu_select !== 3'd0 || wb_valid !== 1'b0) begin errors++;
         $display("FAIL illegal_n1: alu_op=%0d a=%0d sel=%0d wb_valid=%0d want 0 0 0 0", alu_op, alu_srcA, alu_select, wb_valid); end
      tick(); // N+2
      checks++; if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 32'd0 || wb_tag !== 5'd9) begin errors++;
         $display("FAIL illegal_wb: valid=%0d err=%0d data=%0d tag=%0d want 1 1 0 9", wb_valid, wb_err, wb_data, wb_tag); end
      tick(); // N+3
      checks++; if (wb_valid !== 1'b0 || wb_err !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL illegal_done: valid=%0d err=%0d busy=%0d want 0 0 0", wb_valid, wb_err, busy); end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, OP_DIV, 32'd9, 32'd3, 5'd10);
      tick(); // N+1
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      tick(); // N+2
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %0d want 1", busy); end
      resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || issue_ready !== 1'b0 || wb_valid !== 1'b0 || alu_select !== 3'd0) begin errors++;
         $display("FAIL rstmid_async: busy=%0d ready=%0d wb_valid=%0d sel=%0d want 0 0 0 0",
                  busy, issue_ready, wb_valid, alu_select); end
      tick();
      tick();
      resetn = 1'b1;
      tick();
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0d want 1", issue_ready); end
      for (int c = 0; c < 8; c++) begin
         checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_no_wb c=%0d: wb_valid=%0d busy=%0d want 0 0", c, wb_valid, busy); end
         tick();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      flush  = 1'b0;
      drive(1'b0, OP_NONE, 32'd0, 32'd0, '0);
      test_reset();
      test_mul();
      test_div_mod();
      test_conflict();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/complex_alu_sched.md
Name: complex_alu_sched

Overview:
Issue scheduler for the complex (multi-cycle) ALU: multiply, divide, modulo, shift-left and shift-right units.
- Accepts one operation per cycle over a valid/ready handshake and drives the ALU operation code and operands.
- Times the ALU result-select so each unit's output is steered to the single result port in its completion cycle.
- The ALU has one result port, so the block refuses any issue whose completion cycle collides with one already in flight. This is a writeback-slot reservation scheduler.
- Sits between decode/issue and the exec-stage writeback.

Parameters:
- MUL_LAT, 3: multiply unit latency, cycles from operands presented to result valid.
- DIV_LAT, 6: divide and modulo unit latency.
- SHF_LAT, 1: shift-left and shift-right unit latency.
- MAX_LAT, 8: reservation window depth. Every *_LAT must be in 1..MAX_LAT; violation is an elaboration error.
- TAG_W, 5: width of the destination tag.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all in-flight operations
- issue_valid  in  1  request to issue
- issue_ready  out  1  scheduler can accept issue_op this cycle
- issue_op  in  3  1=mul 2=div 3=mod 4=shl 5=shr; 0,6,7 illegal
- issue_srcA  in  32  operand A
- issue_srcB  in  32  operand B (shifts use bits [4:0])
- issue_tag  in  TAG_W  destination tag
- alu_op  out  3  operation code to ALU (0 = idle, all units see zero A)
- alu_srcA  out  32  operand A to ALU
- alu_srcB  out  32  operand B to ALU
- alu_select  out  3  ALU result-select
- alu_result  in  32  ALU result
- wb_valid  out  1  writeback valid, single-cycle pulse
- wb_tag  out  TAG_W  tag of the completing operation
- wb_data  out  32  result data
- wb_err  out  1  completing operation was an illegal op
- busy  out  1  any operation in flight

Behaviour:
- Reset (resetn=0, asynchronous) clears every output to 0, including issue_ready, and clears all reservation state. issue_ready rises on the first clock edge after resetn deasserts.
- Handshake: transfer occurs on the rising edge where issue_valid & issue_ready.
  - issue_ready may depend on issue_op, flush and internal state, never on issue_valid.
  - Requester holds op, operands and tag stable while valid & !ready.
- Latency L(op): mul=MUL_LAT, div/mod=DIV_LAT, shl/shr=SHF_LAT, illegal=1.
- Timing for a handshake at the edge ending cycle N:
  - Cycle N+1: alu_op, alu_srcA and alu_srcB are registered and presented, for exactly one cycle. They return to 0 the next cycle unless a new issue occurs.
  - Cycle N+L: alu_select equals the op code (0 for illegal).
  - Cycle N+L+1: alu_result is registered into wb_data; wb_valid=1 and wb_tag/wb_err are set. Total latency is L+1 edges after the handshake.
- Reservation vector resv[MAX_LAT:1] shifts down by one each cycle. Issue of op sets bit L(op).
  - issue_ready = !resv_next[L(issue_op)] & !flush, where resv_next is the post-shift value.
  - Shorter ops may therefore overtake longer ones; wb_tag identifies each result.
- Per-slot side pipelines carry tag, op code and error flag alongside the reservation bits.
- Idle slot: alu_select=0, so ALU output is 0 and wb_valid=0.
- Illegal op: accepted, alu_op driven 0, completes after 1+1 cycles with wb_data=0 and wb_err=1.
- flush=1:
  - All reservation bits and side pipelines clear on that edge.
  - No wb_valid for any op issued before or during the flush cycle.
  - issue_ready=0 in the flush cycle, so a simultaneous issue_valid is not accepted.
  - ALU internals may still drain; their output is ignored because alu_select=0.
- busy = |resv, including the final writeback cycle.
- resetn asserted mid-operation drops all in-flight results silently.

Decomposition:
- Shared package cx_alu_pkg holds:
  - op code constants OP_NONE, OP_MUL, OP_DIV, OP_MOD, OP_SHL, OP_SHR;
  - a lat_of(op) function;
  - default latency constants.
- One sub-module, cx_slot_pipe: a MAX_LAT-deep shift register of {valid, tag, op, err} with a write-at-index port. It is instantiated once inside complex_alu_sched.

Test Plan:
- Reset release, issue mul 7*6 tag 3 at cycle N -> alu_op=1 at N+1, alu_select=1 at N+3, wb_valid with wb_data=42, wb_tag=3 at N+4.
- Issue div 100/7 tag 1, next cycle mod 100/7 tag 2 -> wb_data=14 tag 1 at N+7, then wb_data=2 tag 2 at N+8.
- Slot conflict: div at N, then mul attempted at N+3 -> issue_ready=0 at N+3 (slot 3 taken); shl at N+3 accepted, completes at N+5, before the div.
- Back-to-back shl 1<<k for k=0..7 with valid held high -> ready always 1, eight consecutive wb_valid pulses with data 1,2,4,...,128.
- Mul in flight, flush at N+1 -> no wb_valid ever for it; busy=0 by N+2; issue_valid during flush not accepted.
- Illegal op 6 tag 9 -> wb_valid, wb_err=1, wb_data=0 at N+2; also resetn pulse mid-div -> all outputs 0 immediately, no later wb_valid.
